// File: rtl/sum_1b_pkg.sv
// Shared arithmetic constants for the adder family.
// Wider adders built from sum_1b select their output staging with these.
package sum_1b_pkg;

    // Output staging selection for sum_1b and the adders built from it
    localparam int REG_OUT_COMB = 0;  // combinational outputs, zero latency
    localparam int REG_OUT_PIPE = 1;  // registered outputs, one-cycle latency

endpackage : sum_1b_pkg

// File: rtl/sum_1b_half_adder.sv
// Half adder: the building block of the full adder cell.
module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic sum_o,
    output logic carry_o
);

    // Sum is the XOR of the inputs; the carry is set only when both are 1
    assign sum_o   = x_i ^ y_i;
    assign carry_o = x_i & y_i;

endmodule : half_adder

// File: rtl/sum_1b.sv
// 1-bit full adder cell: {co, s} = a + b + ci.
// Built from two half adders plus an OR of their carries. It can be
// chained ripple-style (co feeds the next ci). REG_OUT selects
// combinational outputs or a single registered output stage.
module sum_1b
    import sum_1b_pkg::*;
#(
    parameter int REG_OUT = REG_OUT_COMB
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha0_sum, ha0_carry;
    logic ha1_carry;
    logic s_d, co_d;

    // First stage adds the two addend bits
    half_adder u_ha0 (
        .x_i     (a),
        .y_i     (b),
        .sum_o   (ha0_sum),
        .carry_o (ha0_carry)
    );

    // Second stage folds in the carry-in
    half_adder u_ha1 (
        .x_i     (ha0_sum),
        .y_i     (ci),
        .sum_o   (s_d),
        .carry_o (ha1_carry)
    );

    // The two carries can never both be set, so an OR forms the carry-out
    assign co_d = ha0_carry | ha1_carry;

    if (REG_OUT == REG_OUT_PIPE) begin : g_pipe
        logic s_q, co_q;

        // Capture the result every cycle; reset clears it at once and
        // discards any result still in flight
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q  <= 1'b0;
                co_q <= 1'b0;
            end else begin
                s_q  <= s_d;
                co_q <= co_d;
            end
        end

        assign s  = s_q;
        assign co = co_q;
    end else begin : g_comb
        // Clock and reset are intentionally unused in combinational mode
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign s  = s_d;
        assign co = co_d;
    end

endmodule : sum_1b

// File: tb/tb_sum_1b.sv
// Bench for sum_1b: checks a combinational instance and a registered
// instance against a constant truth table through a scoreboard queue.
module tb_sum_1b;

    typedef struct packed {
        logic a;
        logic b;
        logic ci;
        logic co;
        logic s;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, ci;
    logic s_c, co_c, s_p, co_p;

    int checks = 0;
    int errors = 0;

    vec_t       tbl [8];
    logic [1:0] sb_q [$];
    logic [1:0] prev;

    always #5 clk = ~clk;

    sum_1b #(.REG_OUT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .s(s_c), .co(co_c)
    );

    sum_1b #(.REG_OUT(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .s(s_p), .co(co_p)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {co,s}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input string name, input logic [1:0] act);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got {co,s}=%b at %0t", name, act, $time);
        end else begin
            chk(name, act, sb_q.pop_front());
        end
    endtask

    task automatic drive(input vec_t v);
        a  = v.a;
        b  = v.b;
        ci = v.ci;
        sb_q.push_back({v.co, v.s});
    endtask

    initial begin
        // Truth table indexed by {a,b,ci}
        tbl[0] = 5'b000_00;
        tbl[1] = 5'b001_01;
        tbl[2] = 5'b010_01;
        tbl[3] = 5'b011_10;
        tbl[4] = 5'b100_01;
        tbl[5] = 5'b101_10;
        tbl[6] = 5'b110_10;
        tbl[7] = 5'b111_11;

        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; ci = 1'b0;
        #2;

        // Exhaustive sweep: a every 10 ns, b every 20 ns, ci every 40 ns.
        // Registered instance is held in reset throughout and must stay 0.
        for (int t = 0; t < 100; t++) begin
            logic [2:0] tb3;
            logic [2:0] idx;
            tb3 = t[2:0];
            idx = {tb3[0], tb3[1], tb3[2]};
            drive(tbl[idx]);
            #4;
            pop_chk("comb_sweep", {co_c, s_c});
            chk("pipe_in_reset", {co_p, s_p}, 2'b00);
            #6;
        end

        // Clock/reset independence of the combinational instance
        a = 1'b1; b = 1'b0; ci = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst_n = ~rst_n;
            #1;
            chk("comb_indep_neg", {co_c, s_c}, 2'b10);
            @(posedge clk);
            #1;
            chk("comb_indep_pos", {co_c, s_c}, 2'b10);
        end
        // rst_n is low again after an even number of toggles
        @(negedge clk);
        rst_n = 1'b1;
        drive(tbl[0]);
        @(posedge clk);
        #1;
        pop_chk("pipe_first_capture", {co_p, s_p});

        // Registered latency: 111 applied before edge N shows only after it
        @(negedge clk);
        drive(tbl[7]);
        #1;
        chk("lat_hold", {co_p, s_p}, 2'b00);
        @(posedge clk);
        #1;
        pop_chk("lat_edge", {co_p, s_p});

        // Async reset between edges, held while low, then release
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("async_rst_now", {co_p, s_p}, 2'b00);
        @(posedge clk);
        #1;
        chk("async_rst_held", {co_p, s_p}, 2'b00);
        @(negedge clk);
        drive(tbl[2]);
        rst_n = 1'b1;
        #1;
        chk("rst_release_pre", {co_p, s_p}, 2'b00);
        @(posedge clk);
        #1;
        pop_chk("rst_release_edge", {co_p, s_p});

        // Back-to-back pipeline over all 8 codes
        prev = {tbl[2].co, tbl[2].s};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_hold", {co_p, s_p}, prev);
            drive(tbl[i]);
            prev = {tbl[i].co, tbl[i].s};
            @(posedge clk);
            #1;
            pop_chk("b2b_out", {co_p, s_p});
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL b2b_drain: %0d results left, expected 0", sb_q.size());
        end

        // Simultaneous toggle 000 -> 111 in combinational mode
        @(negedge clk);
        {a, b, ci} = 3'b000;
        #1;
        chk("simul_000", {co_c, s_c}, 2'b00);
        {a, b, ci} = 3'b111;
        #1;
        chk("simul_111", {co_c, s_c}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sum_1b
